// File: rtl/biquad8_coeff_loader.sv
// Coefficient loader for the biquad8 filter.
// A small table of {reg address, coefficient} entries is filled while idle.
// On start, the entries are replayed as WISHBONE writes, followed by one
// write to the update register. Every bus write is bounded by a timeout.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; table writable
// FETCH  | table entry at the current index is read
// WRITE  | table entry on the bus, waiting for ack/err/rty/timeout
// UPDATE | write of 1 to address 0x00 (first cycle launches it)
// DONE   | done_o pulse, back to IDLE
// ERROR  | one-cycle abort state, back to IDLE with err_o held
module biquad8_coeff_loader #(
  parameter int NENTRY    = 32,
  parameter int TIMEOUT   = 1023,
  parameter     WBCLKTYPE = "NONE"
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rstn_i,
  input  logic                      tbl_wr_i,
  input  logic [$clog2(NENTRY)-1:0] tbl_adr_i,
  input  logic [24:0]               tbl_dat_i,
  input  logic                      start_i,
  input  logic [$clog2(NENTRY):0]   len_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  output logic                      wb_we_o,
  output logic [6:0]                wb_adr_o,
  output logic [31:0]               wb_dat_o,
  output logic [3:0]                wb_sel_o,
  input  logic                      wb_ack_i,
  input  logic                      wb_err_i,
  input  logic                      wb_rty_i
);

  localparam int AW = $clog2(NENTRY);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [LW-1:0] LEN_MAX  = LW'(NENTRY);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

  // Every register here lives in the wb_clk_i domain, so the clock-type tag
  // has nothing to mark; the block is kept so a tagged build still elaborates.
  if (WBCLKTYPE != "NONE") begin : g_xdom_tag
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_UPDATE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   idx, idx_nxt;
  logic [LW-1:0]   len_q, len_nxt;
  logic [TW-1:0]   tmo, tmo_nxt;
  logic            err_nxt;
  logic            cyc_nxt, stb_nxt, we_nxt;
  logic [6:0]      adr_nxt;
  logic [31:0]     dat_nxt;
  logic [3:0]      sel_nxt;

  logic [24:0]     mem [NENTRY];
  logic [AW-1:0]   ram_adr;
  logic            ram_we;
  logic [24:0]     entry;
  logic            bus_abort;
  logic            more_entries;
  logic            unused_entry_bits;

  // Single RAM port: the host owns it while idle, the sequencer while busy.
  assign ram_we  = tbl_wr_i & ~busy_o;
  assign ram_adr = busy_o ? idx : tbl_adr_i;

  // Read data is only consumed by the bus registers at the end of FETCH,
  // which makes those registers the RAM's one-cycle read register.
  assign entry = mem[ram_adr];

  // The two low address bits are forced to zero on the bus (word aligned).
  assign unused_entry_bits = ^entry[19:18];

  assign bus_abort    = wb_err_i | wb_rty_i | (tmo == '0);
  assign more_entries = ({1'b0, idx} + LW'(1)) < len_q;

  // Table storage; contents deliberately survive reset.
  always_ff @(posedge wb_clk_i) begin
    if (ram_we) begin
      mem[ram_adr] <= tbl_dat_i;
    end
  end

  // Next-state and next-output decode; bus outputs are registered from here.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    len_nxt   = len_q;
    tmo_nxt   = tmo;
    err_nxt   = err_o;
    cyc_nxt   = wb_cyc_o;
    stb_nxt   = wb_stb_o;
    we_nxt    = wb_we_o;
    adr_nxt   = wb_adr_o;
    dat_nxt   = wb_dat_o;
    sel_nxt   = wb_sel_o;

    case (state)
      S_IDLE: begin
        if (start_i) begin
          len_nxt   = (len_i > LEN_MAX) ? LEN_MAX : len_i;
          idx_nxt   = '0;
          err_nxt   = 1'b0;
          state_nxt = (len_i == '0) ? S_UPDATE : S_FETCH;
        end
      end

      S_FETCH: begin
        cyc_nxt   = 1'b1;
        stb_nxt   = 1'b1;
        we_nxt    = 1'b1;
        adr_nxt   = {entry[24:20], 2'b00};
        dat_nxt   = {14'b0, entry[17:0]};
        sel_nxt   = 4'hF;
        tmo_nxt   = TMO_LOAD;
        state_nxt = S_WRITE;
      end

      S_WRITE: begin
        // Ack is tested first so it wins over a coincident timeout.
        if (wb_ack_i) begin
          cyc_nxt = 1'b0;
          stb_nxt = 1'b0;
          we_nxt  = 1'b0;
          if (more_entries) begin
            idx_nxt   = idx + AW'(1);
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_UPDATE;
          end
        end else if (bus_abort) begin
          cyc_nxt   = 1'b0;
          stb_nxt   = 1'b0;
          we_nxt    = 1'b0;
          err_nxt   = 1'b1;
          state_nxt = S_ERROR;
        end else begin
          tmo_nxt = tmo - TW'(1);
        end
      end

      S_UPDATE: begin
        // Entered with stb low so there is always a gap after the last write.
        if (!wb_stb_o) begin
          cyc_nxt = 1'b1;
          stb_nxt = 1'b1;
          we_nxt  = 1'b1;
          adr_nxt = 7'h00;
          dat_nxt = 32'h1;
          sel_nxt = 4'hF;
          tmo_nxt = TMO_LOAD;
        end else if (wb_ack_i) begin
          cyc_nxt   = 1'b0;
          stb_nxt   = 1'b0;
          we_nxt    = 1'b0;
          state_nxt = S_DONE;
        end else if (bus_abort) begin
          cyc_nxt   = 1'b0;
          stb_nxt   = 1'b0;
          we_nxt    = 1'b0;
          err_nxt   = 1'b1;
          state_nxt = S_ERROR;
        end else begin
          tmo_nxt = tmo - TW'(1);
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
      end

      S_ERROR: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, sequencing counters and registered bus/status outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state    <= S_IDLE;
      idx      <= '0;
      len_q    <= '0;
      tmo      <= '0;
      err_o    <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      len_q    <= len_nxt;
      tmo      <= tmo_nxt;
      err_o    <= err_nxt;
      busy_o   <= (state_nxt != S_IDLE);
      done_o   <= (state_nxt == S_DONE);
      wb_cyc_o <= cyc_nxt;
      wb_stb_o <= stb_nxt;
      wb_we_o  <= we_nxt;
      wb_adr_o <= adr_nxt;
      wb_dat_o <= dat_nxt;
      wb_sel_o <= sel_nxt;
    end
  end

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// Bench for biquad8_coeff_loader: a WISHBONE slave model checks each write
// against a queue of expected writes pushed by the scenario tasks.
module tb_biquad8_coeff_loader;

  localparam int NENTRY = 32;
  localparam int AW     = 5;
  localparam int TMO    = 15;

  typedef struct packed {
    logic [6:0]  adr;
    logic [31:0] dat;
  } wr_t;

  logic          wb_clk_i = 1'b0;
  logic          wb_rstn_i;
  logic          tbl_wr_i;
  logic [AW-1:0] tbl_adr_i;
  logic [24:0]   tbl_dat_i;
  logic          start_i;
  logic [AW:0]   len_i;
  logic          busy_o, done_o, err_o;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [6:0]    wb_adr_o;
  logic [31:0]   wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic          wb_ack_i, wb_err_i, wb_rty_i;

  wr_t         exp_q[$];
  logic [24:0] shadow [NENTRY];

  int checks       = 0;
  int failures     = 0;
  int cyc_num      = 0;
  int done_cnt     = 0;
  int wr_count     = 0;
  int ack_dly      = 2;
  bit never_ack    = 0;
  int err_on_write = 0;
  bit use_rty      = 0;
  int last_dur     = 0;
  int rise_cyc     = 0;

  biquad8_coeff_loader #(
    .NENTRY   (NENTRY),
    .TIMEOUT  (TMO),
    .WBCLKTYPE("NONE")
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rstn_i(wb_rstn_i),
    .tbl_wr_i (tbl_wr_i),
    .tbl_adr_i(tbl_adr_i),
    .tbl_dat_i(tbl_dat_i),
    .start_i  (start_i),
    .len_i    (len_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .err_o    (err_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i),
    .wb_rty_i (wb_rty_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial forever begin
    @(posedge wb_clk_i);
    cyc_num++;
  end

  initial forever begin
    @(negedge wb_clk_i);
    if (done_o === 1'b1) done_cnt++;
  end

  // Slave model: pops the scoreboard on each new write, checks hold and the
  // no-stb-after-response rule, and answers with ack/err/rty.
  initial begin
    bit   in_wr;
    bit   resp;
    int   wcnt;
    wr_t  cur;
    in_wr = 0; resp = 0; wcnt = 0; cur = '0;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    forever begin
      @(negedge wb_clk_i);
      if (resp) begin
        checks++;
        if (wb_stb_o !== 1'b0) begin
          failures++;
          $display("FAIL stb_after_response: stb=%b required 0", wb_stb_o);
        end
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
        resp = 0; in_wr = 0;
      end else if (in_wr) begin
        if (!(wb_cyc_o === 1'b1 && wb_stb_o === 1'b1)) begin
          in_wr    = 0;
          last_dur = cyc_num - rise_cyc;
        end else begin
          checks++;
          if ({wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o} !== {cur.adr, cur.dat, 4'hF, 1'b1}) begin
            failures++;
            $display("FAIL bus_hold: adr=%h dat=%h sel=%h we=%b required adr=%h dat=%h sel=f we=1",
                     wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, cur.adr, cur.dat);
          end
        end
      end
      if (!in_wr && !resp && wb_stb_o === 1'b1) begin
        in_wr    = 1;
        wcnt     = 0;
        wr_count++;
        rise_cyc = cyc_num;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          cur = {wb_adr_o, wb_dat_o};
          $display("FAIL unexpected_write: adr=%h dat=%h required no write", wb_adr_o, wb_dat_o);
        end else begin
          cur = exp_q.pop_front();
          if ({wb_cyc_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o} !== {1'b1, cur.adr, cur.dat, 4'hF, 1'b1}) begin
            failures++;
            $display("FAIL write_content: cyc=%b adr=%h dat=%h sel=%h we=%b required cyc=1 adr=%h dat=%h sel=f we=1",
                     wb_cyc_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, cur.adr, cur.dat);
          end
        end
      end
      if (in_wr && !resp) begin
        wcnt++;
        if (!never_ack && wcnt == ack_dly) begin
          if (wr_count == err_on_write) begin
            if (use_rty) wb_rty_i = 1'b1;
            else         wb_err_i = 1'b1;
          end else begin
            wb_ack_i = 1'b1;
          end
          resp = 1;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  task automatic write_tbl(input int i, input logic [6:0] a, input logic [17:0] c);
    @(negedge wb_clk_i);
    tbl_wr_i  = 1'b1;
    tbl_adr_i = AW'(i);
    tbl_dat_i = {a, c};
    shadow[i] = {a, c};
    @(negedge wb_clk_i);
    tbl_wr_i  = 1'b0;
  endtask

  task automatic push_exp(input logic [6:0] a, input logic [31:0] d);
    exp_q.push_back(wr_t'({a, d}));
  endtask

  task automatic push_entry(input int i);
    push_exp({shadow[i][24:20], 2'b00}, {14'b0, shadow[i][17:0]});
  endtask

  task automatic pulse_start(input logic [AW:0] len);
    @(negedge wb_clk_i);
    start_i = 1'b1;
    len_i   = len;
    @(negedge wb_clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_idle(output bit to);
    to = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge wb_clk_i);
      if (busy_o === 1'b0) begin
        to = 0;
        break;
      end
    end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    wr_count     = 0;
    done_cnt     = 0;
    never_ack    = 0;
    err_on_write = 0;
    use_rty      = 0;
  endtask

  task automatic test_reset();
    wb_rstn_i = 1'b0;
    tbl_wr_i = 1'b0; tbl_adr_i = '0; tbl_dat_i = '0; start_i = 1'b0; len_i = '0;
    repeat (3) @(negedge wb_clk_i);
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin
      failures++; $display("FAIL reset_ctl: cyc/stb/we=%b required 000", {wb_cyc_o, wb_stb_o, wb_we_o});
    end
    checks++;
    if ({busy_o, done_o, err_o} !== 3'b000) begin
      failures++; $display("FAIL reset_status: busy/done/err=%b required 000", {busy_o, done_o, err_o});
    end
    checks++;
    if ({wb_adr_o, wb_dat_o, wb_sel_o} !== 43'd0) begin
      failures++; $display("FAIL reset_bus: adr=%h dat=%h sel=%h required 0", wb_adr_o, wb_dat_o, wb_sel_o);
    end
    wb_rstn_i = 1'b1;
  endtask

  task automatic test_basic_load();
    bit to;
    clear_sb();
    ack_dly = 2;
    write_tbl(0, 7'h04, 18'h01000);
    write_tbl(1, 7'h08, 18'h3FFFF);
    write_tbl(2, 7'h14, 18'h00123);
    push_exp(7'h04, 32'h0000_1000);
    push_exp(7'h08, 32'h0003_FFFF);
    push_exp(7'h14, 32'h0000_0123);
    push_exp(7'h00, 32'h0000_0001);
    pulse_start(6'd3);
    wait_idle(to);
    checks++;
    if (to) begin failures++; $display("FAIL basic_idle: busy stuck, required idle"); end
    checks++;
    if (exp_q.size() != 0 || wr_count != 4) begin
      failures++; $display("FAIL basic_writes: writes=%0d pending=%0d required 4 and 0", wr_count, exp_q.size());
    end
    checks++;
    if (done_cnt != 1 || err_o !== 1'b0) begin
      failures++; $display("FAIL basic_status: done_pulses=%0d err=%b required 1 and 0", done_cnt, err_o);
    end
  endtask

  task automatic test_len_zero();
    bit to;
    clear_sb();
    push_exp(7'h00, 32'h1);
    pulse_start(6'd0);
    wait_idle(to);
    checks++;
    if (to || exp_q.size() != 0 || wr_count != 1 || done_cnt != 1) begin
      failures++;
      $display("FAIL len_zero: timeout=%b writes=%0d pending=%0d done=%0d required 0 1 0 1",
               to, wr_count, exp_q.size(), done_cnt);
    end
  endtask

  task automatic test_timeout();
    bit to;
    clear_sb();
    never_ack = 1;
    push_entry(0);
    pulse_start(6'd1);
    wait_idle(to);
    repeat (2) @(negedge wb_clk_i);
    checks++;
    if (to || last_dur != TMO) begin
      failures++; $display("FAIL timeout_len: cycles=%0d stuck=%b required %0d and 0", last_dur, to, TMO);
    end
    checks++;
    if (err_o !== 1'b1 || done_cnt != 0 || wr_count != 1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL timeout_abort: err=%b done=%0d writes=%0d required err=1 done=0 writes=1",
               err_o, done_cnt, wr_count);
    end
    never_ack = 0;
    push_exp(7'h00, 32'h1);
    @(negedge wb_clk_i);
    start_i = 1'b1;
    len_i   = 6'd0;
    @(posedge wb_clk_i);
    #1;
    checks++;
    if (err_o !== 1'b0 || busy_o !== 1'b1) begin
      failures++; $display("FAIL err_clear: err=%b busy=%b required 0 and 1", err_o, busy_o);
    end
    @(negedge wb_clk_i);
    start_i = 1'b0;
    wait_idle(to);
    checks++;
    if (to || done_cnt != 1 || exp_q.size() != 0) begin
      failures++; $display("FAIL after_timeout_run: done=%0d pending=%0d required 1 and 0", done_cnt, exp_q.size());
    end
  endtask

  task automatic test_bus_abort(input bit rty, input int which);
    bit to;
    clear_sb();
    use_rty      = rty;
    err_on_write = which;
    for (int i = 0; i < which; i++) push_entry(i);
    pulse_start(6'd3);
    wait_idle(to);
    repeat (3) @(negedge wb_clk_i);
    checks++;
    if (to || err_o !== 1'b1 || done_cnt != 0) begin
      failures++; $display("FAIL abort_status rty=%0d: err=%b done=%0d required 1 and 0", rty, err_o, done_cnt);
    end
    checks++;
    if (wr_count != which || exp_q.size() != 0) begin
      failures++; $display("FAIL abort_writes rty=%0d: writes=%0d required %0d", rty, wr_count, which);
    end
  endtask

  task automatic test_busy_ignore();
    bit to;
    clear_sb();
    for (int i = 0; i < 3; i++) push_entry(i);
    push_exp(7'h00, 32'h1);
    pulse_start(6'd3);
    repeat (2) @(negedge wb_clk_i);
    checks++;
    if (busy_o !== 1'b1) begin failures++; $display("FAIL busy_during_run: busy=%b required 1", busy_o); end
    start_i = 1'b1; len_i = 6'd0;
    tbl_wr_i = 1'b1; tbl_adr_i = AW'(1); tbl_dat_i = {7'h1C, 18'h2AAAA};
    @(negedge wb_clk_i);
    start_i = 1'b0; tbl_wr_i = 1'b0;
    wait_idle(to);
    repeat (4) @(negedge wb_clk_i);
    checks++;
    if (to || busy_o !== 1'b0 || done_cnt != 1 || wr_count != 4 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL busy_ignore_run: busy=%b done=%0d writes=%0d pending=%0d required 0 1 4 0",
               busy_o, done_cnt, wr_count, exp_q.size());
    end
    clear_sb();
    push_entry(0);
    push_entry(1);
    push_exp(7'h00, 32'h1);
    pulse_start(6'd2);
    wait_idle(to);
    checks++;
    if (to || wr_count != 3 || exp_q.size() != 0 || done_cnt != 1) begin
      failures++; $display("FAIL table_unchanged: writes=%0d pending=%0d required 3 and 0", wr_count, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_write();
    bit to;
    bit seen;
    clear_sb();
    for (int i = 0; i < 3; i++) push_entry(i);
    pulse_start(6'd3);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge wb_clk_i);
      if (wb_stb_o === 1'b1) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL rst_mid_stb: stb never rose, required 1"); end
    #2 wb_rstn_i = 1'b0;
    #1;
    checks++;
    if ({wb_cyc_o, wb_stb_o, busy_o} !== 3'b000) begin
      failures++; $display("FAIL rst_mid_drop: cyc/stb/busy=%b required 000", {wb_cyc_o, wb_stb_o, busy_o});
    end
    @(negedge wb_clk_i);
    clear_sb();
    for (int i = 0; i < 3; i++) push_entry(i);
    push_exp(7'h00, 32'h1);
    start_i   = 1'b1;
    len_i     = 6'd3;
    wb_rstn_i = 1'b1;
    @(posedge wb_clk_i);
    #1;
    checks++;
    if (busy_o !== 1'b1) begin failures++; $display("FAIL rst_first_edge_start: busy=%b required 1", busy_o); end
    @(negedge wb_clk_i);
    start_i = 1'b0;
    wait_idle(to);
    checks++;
    if (to || wr_count != 4 || exp_q.size() != 0 || done_cnt != 1 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_rerun: writes=%0d pending=%0d done=%0d err=%b required 4 0 1 0",
               wr_count, exp_q.size(), done_cnt, err_o);
    end
  endtask

  task automatic test_saturate();
    bit to;
    logic [6:0] adrs [6];
    adrs = '{7'h04, 7'h08, 7'h10, 7'h14, 7'h18, 7'h1C};
    clear_sb();
    ack_dly = 1;
    for (int i = 0; i < NENTRY; i++) write_tbl(i, adrs[i % 6], 18'($urandom));
    for (int i = 0; i < NENTRY; i++) push_entry(i);
    push_exp(7'h00, 32'h1);
    pulse_start(6'd40);
    wait_idle(to);
    checks++;
    if (to || wr_count != NENTRY + 1 || exp_q.size() != 0 || done_cnt != 1) begin
      failures++;
      $display("FAIL saturate: writes=%0d pending=%0d done=%0d required %0d 0 1",
               wr_count, exp_q.size(), done_cnt, NENTRY + 1);
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_len_zero();
    test_timeout();
    test_bus_abort(1'b0, 2);
    test_bus_abort(1'b1, 1);
    test_busy_ignore();
    test_reset_mid_write();
    test_saturate();
    repeat (3) @(negedge wb_clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/biquad8_coeff_loader.md
BIQUAD8_COEFF_LOADER -- requirements
Module: biquad8_coeff_loader

Interface
REQ-001 Parameter NENTRY, default 32: depth of the coefficient table, in entries.
REQ-002 Parameter TIMEOUT, default 1023: maximum wb_clk_i cycles allowed per bus write while waiting for ack.
REQ-003 Parameter WBCLKTYPE, default "NONE": clock-type tag applied to registers that cross domains.
REQ-004 wb_clk_i  in  1  sole clock; all logic is in this domain.
REQ-005 wb_rstn_i  in  1  reset, asynchronous assert, active-low.
REQ-006 tbl_wr_i  in  1  table write strobe.
REQ-007 tbl_adr_i  in  $clog2(NENTRY)  table write index.
REQ-008 tbl_dat_i  in  25  table entry: bits [24:18] are the biquad register address, bits [17:0] are the coefficient.
REQ-009 start_i  in  1  single-cycle request to run a load sequence.
REQ-010 len_i  in  $clog2(NENTRY)+1  number of table entries to send; sampled when start is accepted.
REQ-011 busy_o  out  1  high while a sequence is running.
REQ-012 done_o  out  1  single-cycle pulse when a sequence completes successfully.
REQ-013 err_o  out  1  sticky error flag; cleared by the next accepted start.
REQ-014 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  WISHBONE master controls.
REQ-015 wb_adr_o  out  7  WISHBONE address.
REQ-016 wb_dat_o  out  32  WISHBONE write data.
REQ-017 wb_sel_o  out  4  WISHBONE byte selects.
REQ-018 wb_ack_i, wb_err_i, wb_rty_i  in  1 each  WISHBONE slave responses.

Function
REQ-019 The block SHALL drive the biquad8 filter's 7-bit WISHBONE target port: 0x04 FIR, 0x08 IIR, 0x10-0x1C pole-FIR, 0x00 update.
REQ-020 The table SHALL be a synchronous single-port RAM of NENTRY x 25 bits with one-cycle read latency.
REQ-021 A table write SHALL occur when tbl_wr_i=1 and busy_o=0; when busy_o=1, tbl_wr_i SHALL be ignored.
REQ-022 The FSM SHALL have states IDLE, FETCH, WRITE, UPDATE, DONE and ERROR.
REQ-023 IDLE -> FETCH on start_i with len_i>0; IDLE -> UPDATE on start_i with len_i=0; either transition latches len_i, zeroes the index and clears err_o.
REQ-024 start_i SHALL be ignored in every state except IDLE.
REQ-025 FETCH SHALL last exactly one cycle for the RAM read, then go to WRITE.
REQ-026 In WRITE: cyc, stb and we = 1; adr = {entry[24:20], 2'b00}; dat = {14'b0, entry[17:0]}; sel = 4'hF.
REQ-027 In WRITE, all bus outputs SHALL hold stable until a response is seen.
REQ-028 Bus outputs SHALL be registered; cyc and stb SHALL deassert on the clock edge at which wb_ack_i=1 is sampled, so stb is never high in the cycle after ack.
REQ-029 After an acked WRITE: if the index is below len-1, increment it and go to FETCH (stb is low for at least one cycle between writes); otherwise go to UPDATE.
REQ-030 UPDATE SHALL perform one write of adr=0x00, dat=32'h1, sel=4'hF, with the same ack rule as WRITE, then go to DONE.
REQ-031 DONE SHALL pulse done_o for one cycle and then return to IDLE.
REQ-032 busy_o SHALL be 1 in all states except IDLE.
REQ-033 A timeout counter SHALL reset at the start of each bus write; if it reaches TIMEOUT with no ack, drop cyc/stb, set err_o and go to ERROR.
REQ-034 wb_err_i=1 or wb_rty_i=1 during a write SHALL abort the sequence identically to a timeout, with no retry.
REQ-035 ERROR SHALL last one cycle, then go to IDLE; done_o SHALL NOT pulse, and the update write SHALL NOT be issued.
REQ-036 If ack and timeout coincide in the same cycle, ack SHALL win.
REQ-037 len_i > NENTRY SHALL be saturated to NENTRY.

Reset
REQ-038 On wb_rstn_i=0, immediately and asynchronously: FSM=IDLE; cyc, stb, we, busy_o, done_o, err_o = 0; adr, dat, sel = 0; index and timeout counter = 0.
REQ-039 Reset mid-write SHALL drop cyc/stb without waiting for ack; table contents are not reset.
REQ-040 After reset release, the first active clock edge SHALL be able to accept start_i.

Verification
REQ-041 Load 3 entries {0x04,0x1000},{0x08,0x3FFFF},{0x14,0x00123}; start with len=3; slave acks 2 cycles after stb -> four writes to 0x04, 0x08, 0x14, 0x00 with data 0x1000, 0x3FFFF, 0x123, 0x1; stb low between writes; one done_o pulse; err_o=0.
REQ-042 start with len=0 -> a single write to 0x00 with data 0x1, then done_o.
REQ-043 Slave never acks, TIMEOUT=15 -> cyc drops 15 cycles after stb rises; err_o=1; no done_o; no write to 0x00; the next start clears err_o.
REQ-044 wb_err_i asserted on the second write of 3 -> abort, err_o=1, no further writes.
REQ-045 Assert wb_rstn_i low while stb=1 -> cyc, stb and busy_o go to 0 before the next clock edge; after release, a new start runs normally using the retained table.
REQ-046 start_i and tbl_wr_i pulsed while busy -> both ignored; the sequence and table contents are unchanged.
